// File: rtl/rgb_seq_pkg.sv
// ============================================================================
// Module      : rgb_seq_pkg
// Description : Shared types, default constants and segment helper for the
//               RGB hue-wheel sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rgb_seq_pkg;

    localparam int unsigned c_STEP_CYCLES_DEFAULT = 7812;
    localparam int unsigned c_PWM_BITS_DEFAULT    = 8;

    typedef enum logic [2:0] {
        SEG_R_G_UP = 3'd0,
        SEG_R_DN   = 3'd1,
        SEG_B_UP   = 3'd2,
        SEG_G_DN   = 3'd3,
        SEG_R_UP   = 3'd4,
        SEG_B_DN   = 3'd5
    } hue_seg_t;

    function automatic hue_seg_t seg_next(input hue_seg_t s);
        if (s == SEG_B_DN)
            return SEG_R_G_UP;
        return hue_seg_t'(s + 3'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rgb_pwm_channel.sv
// ============================================================================
// Module      : rgb_pwm_channel
// Description : One PWM comparator with a registered, polarity-adjusted pin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rgb_pwm_channel #(
    parameter int unsigned PWM_BITS       = 8,
    parameter bit          LED_ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] i_duty,
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    output logic                o_pin
);

    localparam logic [PWM_BITS-1:0] c_MAX = '1;

    logic w_on;
    logic r_pin;

    // Full-scale duty forces the channel solidly on instead of 255/256.
    assign w_on = (i_duty == c_MAX) || (i_pwm_cnt < i_duty);

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_pin <= LED_ACTIVE_LOW;
        else
            r_pin <= w_on ^ LED_ACTIVE_LOW;
    end

    assign o_pin = r_pin;

endmodule

`default_nettype wire

// File: rtl/rgb_hue_sequencer.sv
// ============================================================================
// Module      : rgb_hue_sequencer
// Description : Step timer, six-segment hue FSM, duty mux and shared PWM
//               counter driving the on-board RGB LED.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rgb_hue_sequencer
    import rgb_seq_pkg::*;
#(
    parameter int unsigned STEP_CYCLES    = c_STEP_CYCLES_DEFAULT,
    parameter int unsigned PWM_BITS       = c_PWM_BITS_DEFAULT,
    parameter bit          LED_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       RGB_R,
    output logic       RGB_G,
    output logic       RGB_B,
    output logic [2:0] seg_o,
    output logic       cycle_done
);

    localparam int unsigned           c_TW         = $clog2(STEP_CYCLES + 1);
    localparam logic [c_TW-1:0]       c_TIMER_LAST = c_TW'(STEP_CYCLES - 1);
    localparam logic [PWM_BITS-1:0]   c_MAX        = '1;

    logic [c_TW-1:0]     r_timer;
    logic [PWM_BITS-1:0] r_ramp;
    hue_seg_t            r_seg;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic                r_cycle_done;

    logic                w_tick;
    logic                w_ramp_max;
    logic [PWM_BITS-1:0] w_rise;
    logic [PWM_BITS-1:0] w_fall;
    logic [PWM_BITS-1:0] w_duty_r;
    logic [PWM_BITS-1:0] w_duty_g;
    logic [PWM_BITS-1:0] w_duty_b;

    // Gating the tick with en makes a pause land exactly on the frozen count.
    assign w_tick     = en && (r_timer == c_TIMER_LAST);
    assign w_ramp_max = (r_ramp == c_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_timer      <= '0;
            r_ramp       <= '0;
            r_seg        <= SEG_R_G_UP;
            r_pwm_cnt    <= '0;
            r_cycle_done <= 1'b0;
        end else begin
            r_pwm_cnt    <= r_pwm_cnt + PWM_BITS'(1);
            r_cycle_done <= w_tick && w_ramp_max && (r_seg == SEG_B_DN);
            if (w_tick) begin
                r_timer <= '0;
                r_ramp  <= r_ramp + PWM_BITS'(1);
                if (w_ramp_max)
                    r_seg <= seg_next(r_seg);
            end else if (en) begin
                r_timer <= r_timer + c_TW'(1);
            end
        end
    end

    assign w_rise = r_ramp;
    assign w_fall = c_MAX - r_ramp;

    always_comb begin
        w_duty_r = '0;
        w_duty_g = '0;
        w_duty_b = '0;
        case (r_seg)
            SEG_R_G_UP: begin w_duty_r = c_MAX;  w_duty_g = w_rise; end
            SEG_R_DN:   begin w_duty_r = w_fall; w_duty_g = c_MAX;  end
            SEG_B_UP:   begin w_duty_g = c_MAX;  w_duty_b = w_rise; end
            SEG_G_DN:   begin w_duty_g = w_fall; w_duty_b = c_MAX;  end
            SEG_R_UP:   begin w_duty_r = w_rise; w_duty_b = c_MAX;  end
            SEG_B_DN:   begin w_duty_r = c_MAX;  w_duty_b = w_fall; end
            default:    begin w_duty_r = '0;     w_duty_g = '0;     end
        endcase
    end

    rgb_pwm_channel #(
        .PWM_BITS       (PWM_BITS),
        .LED_ACTIVE_LOW (LED_ACTIVE_LOW)
    ) u_pwm_r (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_duty    (w_duty_r),
        .i_pwm_cnt (r_pwm_cnt),
        .o_pin     (RGB_R)
    );

    rgb_pwm_channel #(
        .PWM_BITS       (PWM_BITS),
        .LED_ACTIVE_LOW (LED_ACTIVE_LOW)
    ) u_pwm_g (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_duty    (w_duty_g),
        .i_pwm_cnt (r_pwm_cnt),
        .o_pin     (RGB_G)
    );

    rgb_pwm_channel #(
        .PWM_BITS       (PWM_BITS),
        .LED_ACTIVE_LOW (LED_ACTIVE_LOW)
    ) u_pwm_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_duty    (w_duty_b),
        .i_pwm_cnt (r_pwm_cnt),
        .o_pin     (RGB_B)
    );

    assign seg_o      = r_seg;
    assign cycle_done = r_cycle_done;

endmodule

`default_nettype wire

// File: tb/tb_rgb_hue_sequencer.sv
// ============================================================================
// Module      : tb_rgb_hue_sequencer
// Description : Self-checking bench for rgb_hue_sequencer (both polarities)
//               against an arithmetic hue-wheel model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rgb_hue_sequencer;

    localparam int c_STEP   = 2;
    localparam int c_BITS   = 4;
    localparam int c_MAXV   = 15;
    localparam int c_PERIOD = 16;
    localparam int c_WHEEL  = 6 * c_PERIOD * c_STEP;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic       r_lo, g_lo, b_lo, cd_lo;
    logic       r_hi, g_hi, b_hi, cd_hi;
    logic [2:0] seg_lo, seg_hi;

    int n_checks = 0;
    int n_errors = 0;
    int m_edges  = 0;
    int m_en     = 0;

    // Duty source per channel and segment: 0=zero 1=max 2=rise 3=fall
    int c_tbl [3][6] = '{'{1, 3, 0, 0, 2, 1},
                         '{2, 1, 1, 3, 0, 0},
                         '{0, 0, 2, 1, 1, 3}};

    always #5 clk = ~clk;

    rgb_hue_sequencer #(
        .STEP_CYCLES (c_STEP), .PWM_BITS (c_BITS), .LED_ACTIVE_LOW (1'b1)
    ) u_dut_lo (
        .clk (clk), .rst_n (rst_n), .en (en),
        .RGB_R (r_lo), .RGB_G (g_lo), .RGB_B (b_lo),
        .seg_o (seg_lo), .cycle_done (cd_lo)
    );

    rgb_hue_sequencer #(
        .STEP_CYCLES (c_STEP), .PWM_BITS (c_BITS), .LED_ACTIVE_LOW (1'b0)
    ) u_dut_hi (
        .clk (clk), .rst_n (rst_n), .en (en),
        .RGB_R (r_hi), .RGB_G (g_hi), .RGB_B (b_hi),
        .seg_o (seg_hi), .cycle_done (cd_hi)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int seg_of(input int n);
        return (n / c_STEP / c_PERIOD) % 6;
    endfunction

    function automatic int duty_of(input int n, input int ch);
        int ramp;
        int code;
        ramp = (n / c_STEP) % c_PERIOD;
        code = c_tbl[ch][seg_of(n)];
        case (code)
            1:       return c_MAXV;
            2:       return ramp;
            3:       return c_MAXV - ramp;
            default: return 0;
        endcase
    endfunction

    // One clock: apply inputs, predict, advance, compare on the falling edge.
    task automatic step(input logic r, input logic e);
        logic [2:0] on;
        logic       cd_exp;
        int         d;
        rst_n = r;
        en    = e;
        for (int ch = 0; ch < 3; ch++) begin
            d      = duty_of(m_en, ch);
            on[ch] = (d == c_MAXV) || ((m_edges % c_PERIOD) < d);
        end
        if (!r) begin
            m_edges = 0;
            m_en    = 0;
            on      = 3'b000;
            cd_exp  = 1'b0;
        end else begin
            m_edges++;
            if (e) m_en++;
            cd_exp = e && ((m_en % c_WHEEL) == 0);
        end
        @(posedge clk);
        @(negedge clk);
        check("rgb_r_al", {31'd0, r_lo}, {31'd0, ~on[0]});
        check("rgb_g_al", {31'd0, g_lo}, {31'd0, ~on[1]});
        check("rgb_b_al", {31'd0, b_lo}, {31'd0, ~on[2]});
        check("rgb_r_ah", {31'd0, r_hi}, {31'd0, on[0]});
        check("rgb_g_ah", {31'd0, g_hi}, {31'd0, on[1]});
        check("rgb_b_ah", {31'd0, b_hi}, {31'd0, on[2]});
        check("seg_al", {29'd0, seg_lo}, seg_of(m_en));
        check("seg_ah", {29'd0, seg_hi}, seg_of(m_en));
        check("cdone_al", {31'd0, cd_lo}, {31'd0, cd_exp});
        check("cdone_ah", {31'd0, cd_hi}, {31'd0, cd_exp});
    endtask

    initial begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);

        // Full wheel from reset, including the 5->0 wrap pulse.
        for (int i = 0; i < 200; i++) step(1'b1, 1'b1);

        // Into the middle of S2, then pause and resume.
        for (int i = 0; i < 72; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 50; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 60; i++) step(1'b1, 1'b1);

        // Reach S4 and reset mid-segment.
        for (int i = 0; i < 400 && seg_of(m_en) != 4; i++) step(1'b1, 1'b1);
        check("reach_s4", seg_of(m_en), 4);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        for (int i = 0; i < 200; i++) step(1'b1, 1'b1);

        // Random enable pattern with occasional resets.
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 499) != 0), ($urandom_range(0, 3) != 0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
